// File: rtl/atari_audio_pkg.sv
// Shared audio types and constants for the console audio path.
// Pure declarations, no logic and no latency.
// No flow control; consumers apply their own handshakes.
package atari_audio_pkg;

   typedef logic [15:0] sample_t;

   typedef struct packed {
      sample_t l;
      sample_t r;
   } stereo_t;

   // Default window size: 1024 clk_sys-rate strobes per output sample.
   localparam int AUDIO_DECIM_DEFAULT = 10;

endpackage

// File: rtl/audio_boxcar.sv
// One-channel box-car accumulator; avg is the truncated window mean including the current x.
// Combinational avg; the accumulator updates on the edge that samples ce.
// No back-pressure here; the caller decides whether avg is kept or dropped.
module audio_boxcar
   import atari_audio_pkg::*;
#(
   parameter int IN_W       = 16,
   parameter int LOG2_DECIM = AUDIO_DECIM_DEFAULT
) (
   input  logic            clk_sys,
   input  logic            reset_n,
   input  logic            ce,
   input  logic            last,
   input  logic [IN_W-1:0] x,
   output logic [IN_W-1:0] avg
);

   localparam int ACC_W = IN_W + LOG2_DECIM;

   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_d;
   logic [ACC_W-1:0] sum;

   // Headroom of LOG2_DECIM bits means the window sum can never wrap.
   assign sum = acc_q + {{LOG2_DECIM{1'b0}}, x};
   assign avg = sum[ACC_W-1:LOG2_DECIM];

   // Accumulate on each strobe; the final strobe of a window restarts from zero.
   always_comb begin
      acc_d = acc_q;
      if (ce) begin
         acc_d = last ? '0 : sum;
      end
   end

   // Accumulator register with synchronous reset.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/audio_decimator.sv
// Stereo box-car decimator: averages 2^LOG2_DECIM strobed samples per channel into one output sample.
// out_valid rises on the edge that samples the final strobe of a window.
// A window completing while a sample is held and not accepted is dropped and flags sticky overrun.
module audio_decimator
   import atari_audio_pkg::*;
#(
   parameter int LOG2_DECIM = AUDIO_DECIM_DEFAULT,
   parameter int IN_W       = 16,
   parameter int SIGNED_OUT = 1
) (
   input  logic            clk_sys,
   input  logic            reset_n,
   input  logic            in_ce,
   input  logic [IN_W-1:0] audio_l_in,
   input  logic [IN_W-1:0] audio_r_in,
   input  logic            mute,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [IN_W-1:0] out_l,
   output logic [IN_W-1:0] out_r,
   output logic            overrun,
   input  logic            overrun_clr
);

   localparam logic [LOG2_DECIM-1:0] CNT_ONE  = LOG2_DECIM'(1);
   localparam logic [IN_W-1:0]       MSB_MASK = {1'b1, {(IN_W-1){1'b0}}};

   logic [LOG2_DECIM-1:0] cnt_q, cnt_d;
   logic                  valid_q, valid_d;
   logic [IN_W-1:0]       out_l_q, out_l_d;
   logic [IN_W-1:0]       out_r_q, out_r_d;
   logic                  ovr_q, ovr_d;

   logic                  win_last;
   logic                  win_end;
   logic                  xfer;
   logic                  load;
   logic                  drop;
   logic [IN_W-1:0]       x_l, x_r;
   logic [IN_W-1:0]       avg_l, avg_r;
   logic [IN_W-1:0]       conv_l, conv_r;

   // Muting substitutes zero samples so partial sums already gathered are kept.
   assign x_l = mute ? '0 : audio_l_in;
   assign x_r = mute ? '0 : audio_r_in;

   assign win_last = &cnt_q;
   assign win_end  = in_ce & win_last;
   assign xfer     = valid_q & out_ready;
   assign load     = win_end & (~valid_q | out_ready);
   assign drop     = win_end & valid_q & ~out_ready;

   audio_boxcar #(
      .IN_W       (IN_W),
      .LOG2_DECIM (LOG2_DECIM)
   ) u_box_l (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .ce      (in_ce),
      .last    (win_last),
      .x       (x_l),
      .avg     (avg_l)
   );

   audio_boxcar #(
      .IN_W       (IN_W),
      .LOG2_DECIM (LOG2_DECIM)
   ) u_box_r (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .ce      (in_ce),
      .last    (win_last),
      .x       (x_r),
      .avg     (avg_r)
   );

   // Offset-binary to two's complement is just an MSB flip.
   assign conv_l = (SIGNED_OUT != 0) ? (avg_l ^ MSB_MASK) : avg_l;
   assign conv_r = (SIGNED_OUT != 0) ? (avg_r ^ MSB_MASK) : avg_r;

   // Next state for the shared window counter, output hold register and overrun flag.
   always_comb begin
      cnt_d   = cnt_q;
      valid_d = valid_q;
      out_l_d = out_l_q;
      out_r_d = out_r_q;
      ovr_d   = ovr_q;

      // Counter wraps to zero naturally at the end of each window.
      if (in_ce) begin
         cnt_d = cnt_q + CNT_ONE;
      end

      if (load) begin
         valid_d = 1'b1;
         out_l_d = conv_l;
         out_r_d = conv_r;
      end else if (xfer) begin
         valid_d = 1'b0;
      end

      // A drop in the same cycle as a clear leaves the flag set.
      if (drop) begin
         ovr_d = 1'b1;
      end else if (overrun_clr) begin
         ovr_d = 1'b0;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         valid_q <= 1'b0;
         out_l_q <= '0;
         out_r_q <= '0;
         ovr_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         out_l_q <= out_l_d;
         out_r_q <= out_r_d;
         ovr_q   <= ovr_d;
      end
   end

   assign out_valid = valid_q;
   assign out_l     = out_l_q;
   assign out_r     = out_r_q;
   assign overrun   = ovr_q;

endmodule
